// File: rtl/run_controller.sv
// Run-control sequencer for the single-cycle core: gates instruction commit
// (PC load and register write-back) and tracks why and when execution stopped.
`timescale 1ns/1ps
module run_controller #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             halt_i,
    input  logic             bp_en_i,
    input  logic [XLEN-1:0]  bp_addr_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  instr_i,
    input  logic [CNT_W-1:0] budget_i,
    output logic             pc_en_o,
    output logic [1:0]       state_o,
    output logic             halted_o,
    output logic [2:0]       halt_cause_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [XLEN-1:0] EBREAK_WORD = XLEN'(32'h0010_0073);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE      = 3'd0,
        CAUSE_HALT_REQ  = 3'd1,
        CAUSE_BREAKPT   = 3'd2,
        CAUSE_EBREAK    = 3'd3,
        CAUSE_NULL      = 3'd4,
        CAUSE_BUDGET    = 3'd5,
        CAUSE_STEP_DONE = 3'd6
    } cause_t;

    state_t           state_q, state_d;
    cause_t           cause_q, cause_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] retired_inc;
    logic             skip_q, skip_d;
    logic             active;
    cause_t           stop_cause;

    assign active      = (state_q == RUN) || (state_q == STEP);
    assign retired_inc = (&retired_q) ? retired_q : retired_q + CNT_W'(1);

    // Highest-priority stop reason for the instruction presented this cycle.
    always_comb begin
        stop_cause = CAUSE_NONE;
        if (active) begin
            if ((budget_i != '0) && (retired_q == budget_i))
                stop_cause = CAUSE_BUDGET;
            else if (halt_i)
                stop_cause = CAUSE_HALT_REQ;
            else if (instr_i == EBREAK_WORD)
                stop_cause = CAUSE_EBREAK;
            else if (instr_i == '0)
                stop_cause = CAUSE_NULL;
            else if (bp_en_i && (pc_i == bp_addr_i) && !skip_q)
                stop_cause = CAUSE_BREAKPT;
        end
    end

    assign pc_en_o = active && (stop_cause == CAUSE_NONE) && !rst_i;

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        retired_d = retired_q;
        skip_d    = skip_q;
        case (state_q)
            IDLE: begin
                skip_d  = 1'b0;
                cause_d = CAUSE_NONE;
                if (start_i) begin
                    state_d   = RUN;
                    retired_d = '0;
                end else if (step_i) begin
                    state_d   = STEP;
                    retired_d = '0;
                end
            end
            RUN: begin
                skip_d = 1'b0;
                if (stop_cause != CAUSE_NONE) begin
                    state_d = HALTED;
                    cause_d = stop_cause;
                end else begin
                    retired_d = retired_inc;
                end
            end
            STEP: begin
                skip_d  = 1'b0;
                state_d = HALTED;
                if (stop_cause != CAUSE_NONE) begin
                    cause_d = stop_cause;
                end else begin
                    cause_d   = CAUSE_STEP_DONE;
                    retired_d = retired_inc;
                end
            end
            HALTED: begin
                // Resuming must not re-trigger the breakpoint we are parked on.
                if (start_i) begin
                    state_d = RUN;
                    skip_d  = 1'b1;
                    cause_d = CAUSE_NONE;
                end else if (step_i) begin
                    state_d = STEP;
                    skip_d  = 1'b1;
                    cause_d = CAUSE_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cause_q   <= CAUSE_NONE;
            retired_q <= '0;
            skip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
            skip_q    <= skip_d;
        end
    end

    assign state_o      = state_q;
    assign halted_o     = (state_q == HALTED);
    assign halt_cause_o = cause_q;
    assign retired_o    = retired_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: directed program scenarios plus randomized traffic,
// all checked every cycle against a behavioural run-control model.
`timescale 1ns/1ps
module tb_run_controller;

    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b0, start = 1'b0, step = 1'b0, halt = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = '0, pc = '0, budget = '0;
    logic [31:0] mem [64];
    logic [31:0] instr;
    logic        pc_en, halted;
    logic [1:0]  state;
    logic [2:0]  cause;
    logic [31:0] retired;

    logic        rst4 = 1'b1, start4 = 1'b0;
    logic        pc_en4, halted4;
    logic [1:0]  state4;
    logic [2:0]  cause4;
    logic [3:0]  retired4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign instr = mem[pc[7:2]];

    run_controller #(.XLEN(32), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .step_i(step), .halt_i(halt),
        .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc), .instr_i(instr),
        .budget_i(budget), .pc_en_o(pc_en), .state_o(state), .halted_o(halted),
        .halt_cause_o(cause), .retired_o(retired)
    );

    run_controller #(.XLEN(32), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst4), .start_i(start4), .step_i(1'b0), .halt_i(1'b0),
        .bp_en_i(1'b0), .bp_addr_i(32'h0), .pc_i(32'h0), .instr_i(ADDI),
        .budget_i(4'h0), .pc_en_o(pc_en4), .state_o(state4), .halted_o(halted4),
        .halt_cause_o(cause4), .retired_o(retired4)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: 0 idle, 1 run, 2 step, 3 halted; commit when no stop reason.
    int          m_st = 0;
    logic [2:0]  m_cause = '0;
    logic [31:0] m_ret = '0;
    bit          m_skip = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_active, e_en, was_rst;
    logic [2:0]  c;

    always begin
        @(negedge clk);
        m_active = (m_st == 1) || (m_st == 2);
        c = 3'd0;
        if (m_active) begin
            if (budget != 0 && m_ret == budget) c = 3'd5;
            else if (halt)                      c = 3'd1;
            else if (instr == EBREAK)           c = 3'd3;
            else if (instr == 32'h0)            c = 3'd4;
            else if (bp_en && pc == bp_addr && !m_skip) c = 3'd2;
        end
        e_en = !rst && m_active && (c == 3'd0);
        if (m_valid) begin
            checkOutput("pc_en", {31'b0, pc_en}, {31'b0, e_en});
            checkOutput("state", {30'b0, state}, m_st);
            checkOutput("halted", {31'b0, halted}, (m_st == 3) ? 1 : 0);
            checkOutput("cause", {29'b0, cause}, {29'b0, m_cause});
            checkOutput("retired", retired, m_ret);
        end
        @(posedge clk);
        was_rst = rst;
        if (rst) begin
            m_st = 0; m_cause = 0; m_ret = 0; m_skip = 0; m_valid = 1'b1;
        end else if (m_st == 0) begin
            m_skip = 0;
            if (start || step) begin m_st = start ? 1 : 2; m_ret = 0; end
        end else if (m_st == 3) begin
            if (start || step) begin m_st = start ? 1 : 2; m_skip = 1; m_cause = 0; end
        end else begin
            m_skip = 0;
            if (c != 0) begin
                m_cause = c; m_st = 3;
            end else begin
                if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
                if (m_st == 2) begin m_cause = 3'd6; m_st = 3; end
            end
        end
        #1;
        if (was_rst) pc = '0;
        else if (e_en) pc = pc + 32'd4;
    end

    task automatic applyStimulus(input logic s, input logic st, input logic h);
        @(posedge clk);
        #2;
        start = s; step = st; halt = h;
    endtask

    task automatic doReset();
        @(posedge clk); #2;
        rst = 1'b1; start = 0; step = 0; halt = 0;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic fillAddi();
        for (int i = 0; i < 64; i++) mem[i] = ADDI;
    endtask

    task automatic waitHalted(input string name, input int limit);
        for (int i = 0; i < limit && !halted; i++) begin
            @(posedge clk); #2;
        end
        checkOutput(name, {31'b0, halted}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fillAddi();

        // Free run into a null instruction
        mem[5] = 32'h0;
        doReset();
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        waitHalted("free_halt", 30);
        checkOutput("free_cause", {29'b0, cause}, 32'd4);
        checkOutput("free_retired", retired, 32'd5);
        checkOutput("free_pc", pc, 32'h14);

        // Breakpoint then resume past it
        fillAddi();
        mem[8] = 32'h0;
        bp_en = 1'b1; bp_addr = 32'h8;
        doReset();
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        waitHalted("bp_halt", 30);
        checkOutput("bp_cause", {29'b0, cause}, 32'd2);
        checkOutput("bp_retired", retired, 32'd2);
        checkOutput("bp_pc", pc, 32'h8);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        waitHalted("resume_halt", 30);
        checkOutput("resume_cause", {29'b0, cause}, 32'd4);
        checkOutput("resume_retired", retired, 32'd8);
        checkOutput("resume_pc", pc, 32'h20);
        bp_en = 1'b0;

        // Single step three times
        fillAddi();
        doReset();
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 1, 0);
            applyStimulus(0, 0, 0);
            applyStimulus(0, 0, 0);
            checkOutput("step_halted", {31'b0, halted}, 32'd1);
            checkOutput("step_cause", {29'b0, cause}, 32'd6);
            checkOutput("step_retired", retired, k);
            checkOutput("step_pc", pc, 4 * k);
        end

        // Budget outranks an external halt raised the same cycle
        budget = 32'd3;
        doReset();
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        checkOutput("budget_pc_en", {31'b0, pc_en}, 32'd0);
        applyStimulus(0, 0, 0);
        checkOutput("budget_cause", {29'b0, cause}, 32'd5);
        checkOutput("budget_retired", retired, 32'd3);
        budget = 32'd0;

        // External halt outranks EBREAK
        mem[1] = EBREAK;
        doReset();
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
        checkOutput("prio_cause", {29'b0, cause}, 32'd1);
        checkOutput("prio_retired", retired, 32'd1);
        checkOutput("prio_pc", pc, 32'h4);
        mem[1] = ADDI;

        // Reset in the middle of a run
        doReset();
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        repeat (7) applyStimulus(0, 0, 0);
        checkOutput("midrst_retired", retired, 32'd7);
        rst = 1'b1;
        #1;
        checkOutput("midrst_pc_en", {31'b0, pc_en}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0; start = 1'b1; step = 1'b1;
        checkOutput("midrst_state", {30'b0, state}, 32'd0);
        checkOutput("midrst_cause", {29'b0, cause}, 32'd0);
        checkOutput("midrst_retired0", retired, 32'd0);
        applyStimulus(0, 0, 0);
        checkOutput("both_state", {30'b0, state}, 32'd1);

        // Saturation on the narrow-counter instance
        @(posedge clk); #2;
        rst4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #2;
        start4 = 1'b0;
        repeat (25) @(posedge clk);
        #2;
        checkOutput("sat_retired", {28'b0, retired4}, 32'd15);
        checkOutput("sat_state", {30'b0, state4}, 32'd1);
        checkOutput("sat_pc_en", {31'b0, pc_en4}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 64; i++) begin
            case ($urandom_range(0, 19))
                0:       mem[i] = EBREAK;
                1:       mem[i] = 32'h0;
                default: mem[i] = ADDI;
            endcase
        end
        doReset();
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 14) == 0);
            step  = ($urandom_range(0, 11) == 0);
            halt  = ($urandom_range(0, 29) == 0);
            rst   = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 19) == 0) bp_en = $urandom_range(0, 1);
            if ($urandom_range(0, 19) == 0) bp_addr = {26'b0, 6'($urandom_range(0, 15)) << 2};
            if ($urandom_range(0, 39) == 0)
                budget = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 30));
            if ($urandom_range(0, 9) == 0)
                mem[$urandom_range(0, 63)] = ($urandom_range(0, 3) == 0) ? EBREAK : ADDI;
        end
        start = 0; step = 0; halt = 0; rst = 0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
